// File: rtl/regfile_sequencer.sv
// regfile_sequencer: micro-op sequencer driving the 16-bit register file
// (R1-R4, S1-S4). One command at a time over valid/ready. SWAP runs three
// steps and uses S4 as its temporary.
// Optional build macro: REGFILE_SEQ_SKID_EN adds a one-entry command skid
// buffer, so single-cycle ops can issue back-to-back.
module regfile_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_dst,
  input  logic [2:0]        cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [DATA_W-1:0] rf_outa,
  output logic [DATA_W-1:0] rf_i,
  output logic [2:0]        rf_funsel,
  output logic [3:0]        rf_regsel,
  output logic [3:0]        rf_scrsel,
  output logic [2:0]        rf_outasel,
  output logic [2:0]        rf_outbsel,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;

  localparam logic [2:0] SEL_S4  = 3'd7;

  typedef enum logic [2:0] {IDLE, EXEC, SW1, SW2, SW3} state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [2:0]        dst;
    logic [2:0]        src;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  state_t state;
  cmd_t   cur;
  cmd_t   in_cmd;
  logic   accept;
  logic   final_st;

  assign in_cmd   = {cmd_op, cmd_dst, cmd_src, cmd_imm};
  assign accept   = cmd_valid & cmd_ready;
  assign final_st = (state == EXEC) || (state == SW3);
  assign busy     = (state != IDLE);

  // A SWAP touching S4 as an operand would clobber its own temporary, so it
  // is diverted to a single EXEC cycle that only reports err.
  function automatic state_t first_state(input cmd_t c);
    if (c.op == OP_SWAP && c.dst != SEL_S4 && c.src != SEL_S4)
      first_state = SW1;
    else
      first_state = EXEC;
  endfunction

  // Active-low one-hot enable over {regsel, scrsel}; index 0 = R1 ... 7 = S4.
  function automatic logic [7:0] en_low(input logic [2:0] idx);
    en_low = 8'hFF;
    en_low[3'd7 - idx] = 1'b0;
  endfunction

`ifdef REGFILE_SEQ_SKID_EN
  cmd_t skid;
  logic skid_full;
  assign cmd_ready = !skid_full;
`else
  assign cmd_ready = (state == IDLE);
`endif

  // Sequencer FSM, latched command, registered done/err and optional skid entry.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cur   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef REGFILE_SEQ_SKID_EN
      skid      <= '0;
      skid_full <= 1'b0;
`endif
    end else begin
      done <= final_st;
      err  <= (state == EXEC) && (cur.op == OP_ILL || cur.op == OP_SWAP);
      case (state)
        IDLE: begin
          if (accept) begin
            cur   <= in_cmd;
            state <= first_state(in_cmd);
          end
        end
        EXEC, SW3: begin
`ifdef REGFILE_SEQ_SKID_EN
          // Chain straight into the next command with no IDLE bubble.
          if (skid_full) begin
            cur       <= skid;
            state     <= first_state(skid);
            skid_full <= 1'b0;
          end else if (accept) begin
            cur   <= in_cmd;
            state <= first_state(in_cmd);
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        SW1:     state <= SW2;
        SW2:     state <= SW3;
        default: state <= IDLE;
      endcase
`ifdef REGFILE_SEQ_SKID_EN
      // Mid-SWAP arrivals park in the skid entry until the final step.
      if (accept && busy && !final_st) begin
        skid      <= in_cmd;
        skid_full <= 1'b1;
      end
`endif
    end
  end

  // Register-file control decode from state and latched command.
  always_comb begin
    logic [7:0] en;
    en         = 8'hFF;
    rf_funsel  = FS_LOAD;
    rf_outasel = 3'd0;
    rf_outbsel = 3'd0;
    rf_i       = '0;
    case (state)
      EXEC: begin
        case (cur.op)
          OP_LDI: begin
            rf_i = cur.imm;
            en   = en_low(cur.dst);
          end
          OP_MOV: begin
            rf_outasel = cur.src;
            rf_i       = rf_outa;
            en         = en_low(cur.dst);
          end
          OP_INC: begin
            rf_funsel = FS_INC;
            en        = en_low(cur.dst);
          end
          OP_DEC: begin
            rf_funsel = FS_DEC;
            en        = en_low(cur.dst);
          end
          OP_CLR: begin
            rf_funsel = FS_CLR;
            en        = en_low(cur.dst);
          end
          default: en = 8'hFF;  // NOP, illegal, rejected SWAP
        endcase
      end
      SW1: begin
        rf_outasel = cur.dst;
        rf_i       = rf_outa;
        en         = en_low(SEL_S4);
      end
      SW2: begin
        rf_outasel = cur.src;
        rf_i       = rf_outa;
        en         = en_low(cur.dst);
      end
      SW3: begin
        rf_outasel = SEL_S4;
        rf_i       = rf_outa;
        en         = en_low(cur.src);
      end
      default: en = 8'hFF;
    endcase
    {rf_regsel, rf_scrsel} = en;
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: random + directed commands against a behavioural
// register-file model; a scoreboard queue is checked by a monitor at done.
module tb_regfile_sequencer;
  localparam int W = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0, cmd_dst = '0, cmd_src = '0;
  logic [W-1:0] cmd_imm = '0;
  logic [W-1:0] rf_outa, rf_i;
  logic [2:0]   rf_funsel, rf_outasel, rf_outbsel;
  logic [3:0]   rf_regsel, rf_scrsel;
  logic         done, err, busy;

  regfile_sequencer #(.DATA_W(W)) dut (
    .Clock(Clock), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rf_outa(rf_outa), .rf_i(rf_i), .rf_funsel(rf_funsel),
    .rf_regsel(rf_regsel), .rf_scrsel(rf_scrsel),
    .rf_outasel(rf_outasel), .rf_outbsel(rf_outbsel),
    .done(done), .err(err), .busy(busy)
  );

  // Environment register file reacting to the DUT controls.
  logic [W-1:0] rf [8];
  logic         rf_clr = 1'b1;
  logic [7:0]   en_vec;
  assign en_vec  = {rf_regsel, rf_scrsel};
  assign rf_outa = rf[rf_outasel];

  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) begin
      if (rf_clr) rf[i] <= '0;
      else if (!en_vec[7-i]) begin
        case (rf_funsel)
          3'b000:  rf[i] <= rf[i] - 1'b1;
          3'b001:  rf[i] <= rf[i] + 1'b1;
          3'b010:  rf[i] <= rf_i;
          3'b011:  rf[i] <= '0;
          default: rf[i] <= rf[i];
        endcase
      end
    end
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: register contents after each command, by opcode meaning.
  typedef struct packed {
    logic               e;
    logic [1:0]         nw;
    logic [7:0][W-1:0]  regs;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m [8];

  task automatic model_apply(input logic [2:0] op, dst, src, input logic [W-1:0] imm);
    exp_t x;
    logic [W-1:0] t;
    x.e  = 1'b0;
    x.nw = 2'd1;
    case (op)
      3'd1: m[dst] = imm;
      3'd2: m[dst] = m[src];
      3'd3: begin
        if (dst == 3'd7 || src == 3'd7) begin
          x.e = 1'b1; x.nw = 2'd0;
        end else begin
          t = m[dst]; m[7] = t; m[dst] = m[src]; m[src] = t; x.nw = 2'd3;
        end
      end
      3'd4: m[dst] = m[dst] + 1'b1;
      3'd5: m[dst] = m[dst] - 1'b1;
      3'd6: m[dst] = '0;
      3'd7: begin x.e = 1'b1; x.nw = 2'd0; end
      default: x.nw = 2'd0;
    endcase
    for (int i = 0; i < 8; i++) x.regs[i] = m[i];
    q.push_back(x);
  endtask

  // Monitor: write-cycle sanity every cycle, scoreboard pop on done.
  int   wcnt = 0;
  int   done_cyc[$];
  exp_t ev;
  logic [7:0][W-1:0] act_regs;

  always @(negedge Clock) begin
    if (!Reset) wcnt = 0;
    else begin
      if (done) begin
        done_cyc.push_back(cyc);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected act=1 exp=0");
        end else begin
          ev = q.pop_front();
          chk("err", {31'd0, err}, {31'd0, ev.e});
          chk("write_cycles", wcnt, {30'd0, ev.nw});
          for (int i = 0; i < 8; i++) act_regs[i] = rf[i];
          total++;
          if (act_regs !== ev.regs) begin
            bad++;
            $display("FAIL regs act=%h exp=%h", act_regs, ev.regs);
          end
        end
        wcnt = 0;
      end
      if (en_vec != 8'hFF) begin
        wcnt++;
        chk("onehot_enable", $countones(~en_vec), 1);
        chk("outbsel", {29'd0, rf_outbsel}, 0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, dst, src, input logic [W-1:0] imm);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    while (!cmd_ready && n < 30) begin @(negedge Clock); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout act=0 exp=1");
      cmd_valid = 1'b0;
      return;
    end
    model_apply(op, dst, src, imm);
    @(posedge Clock); #1;
    cmd_valid = 1'b0;
`ifndef REGFILE_SEQ_SKID_EN
    chk("ready_low_after_accept", {31'd0, cmd_ready}, 0);
`endif
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge Clock); n++; end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout act=%0d exp=0", q.size());
    end
    @(negedge Clock);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_regsel"}, {28'd0, rf_regsel}, 32'hF);
    chk({nm, "_scrsel"}, {28'd0, rf_scrsel}, 32'hF);
    chk({nm, "_funsel"}, {29'd0, rf_funsel}, 32'h2);
    chk({nm, "_ready"},  {31'd0, cmd_ready}, 1);
    chk({nm, "_busy"},   {31'd0, busy}, 0);
    chk({nm, "_done"},   {31'd0, done}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] saved [8];
    int sp;
    for (int i = 0; i < 8; i++) m[i] = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk_idle("reset");
    Reset = 1'b1; rf_clr = 1'b0;
    @(negedge Clock);

    // LDI R2
    issue(3'd1, 3'd1, 3'd0, 16'h1234);
    chk("ldi_regsel", {28'd0, rf_regsel}, 32'hB);
    chk("ldi_scrsel", {28'd0, rf_scrsel}, 32'hF);
    chk("ldi_funsel", {29'd0, rf_funsel}, 32'h2);
    chk("ldi_i",      {16'd0, rf_i}, 32'h1234);
    wait_empty();

    // SWAP R1 <-> S1
    issue(3'd1, 3'd0, 3'd0, 16'h00AA);
    issue(3'd1, 3'd4, 3'd0, 16'h5500);
    issue(3'd3, 3'd0, 3'd4, 16'h0);
    chk("sw1_scrsel", {28'd0, rf_scrsel}, 32'hE);
    chk("sw1_regsel", {28'd0, rf_regsel}, 32'hF);
    @(posedge Clock); #1;
    chk("sw2_regsel", {28'd0, rf_regsel}, 32'h7);
    @(posedge Clock); #1;
    chk("sw3_scrsel", {28'd0, rf_scrsel}, 32'h7);
    wait_empty();
    chk("swap_r1", {16'd0, rf[0]}, 32'h5500);
    chk("swap_s4", {16'd0, rf[7]}, 32'h00AA);

    // Rejected commands
    issue(3'd3, 3'd7, 3'd1, 16'h0);
    chk("swap7_enables", {24'd0, en_vec}, 32'hFF);
    issue(3'd7, 3'd2, 3'd1, 16'h0);
    chk("ill_enables", {24'd0, en_vec}, 32'hFF);
    wait_empty();

    // Arithmetic
    issue(3'd1, 3'd3, 3'd0, 16'hFFFF);
    issue(3'd4, 3'd3, 3'd0, 16'h0);
    chk("inc_funsel", {29'd0, rf_funsel}, 32'h1);
    chk("inc_regsel", {28'd0, rf_regsel}, 32'hE);
    issue(3'd6, 3'd5, 3'd0, 16'h0);
    chk("clr_funsel", {29'd0, rf_funsel}, 32'h3);
    chk("clr_scrsel", {28'd0, rf_scrsel}, 32'hB);
    wait_empty();
    chk("inc_wrap", {16'd0, rf[3]}, 32'h0);

    // Back-to-back LDIs: done spacing shows throughput
    done_cyc.delete();
    issue(3'd1, 3'd0, 3'd0, 16'h1111);
    issue(3'd1, 3'd1, 3'd0, 16'h2222);
    issue(3'd1, 3'd2, 3'd0, 16'h3333);
    wait_empty();
`ifdef REGFILE_SEQ_SKID_EN
    sp = 1;
`else
    sp = 2;
`endif
    chk("done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("done_spacing_a", done_cyc[1] - done_cyc[0], sp);
      chk("done_spacing_b", done_cyc[2] - done_cyc[1], sp);
    end

    // Reset in the middle of SW2: S4 keeps the SW1 write, nothing else moves
    for (int i = 0; i < 8; i++) saved[i] = m[i];
    issue(3'd3, 3'd0, 3'd1, 16'h0);
    @(posedge Clock); #2;
    Reset = 1'b0;
    #1;
    chk_idle("midswap_reset");
    void'(q.pop_back());
    for (int i = 0; i < 8; i++) m[i] = saved[i];
    m[7] = saved[0];
    @(negedge Clock);
    chk("midswap_s4", {16'd0, rf[7]}, {16'd0, m[7]});
    chk("midswap_r1", {16'd0, rf[0]}, {16'd0, m[0]});
    chk("midswap_r2", {16'd0, rf[1]}, {16'd0, m[1]});
    #1 Reset = 1'b1;
    @(negedge Clock);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), W'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge Clock); #1; end
    end
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Micro-operation sequencer for the 16-bit register file (R1–R4, S1–S4). It accepts one command at a time over a valid/ready handshake and drives the register file's `FunSel`, `RegSel`, `ScrSel`, `OutASel`, `OutBSel` and `I` inputs for one or more cycles. Multi-cycle operations such as SWAP are built from these steps, and S4 is reserved as the swap temporary. The block sits between the control unit and the register file.

## Interface
- `DATA_W`, default 16, register/data width.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at rising edge.
- `cmd_op`  in  3  opcode: 000 NOP, 001 LDI, 010 MOV, 011 SWAP, 100 INC, 101 DEC, 110 CLR, 111 illegal.
- `cmd_dst`  in  3  destination / swap operand A: 0–3 = R1–R4, 4–7 = S1–S4.
- `cmd_src`  in  3  source / swap operand B, same encoding.
- `cmd_imm`  in  DATA_W  LDI immediate.
- `rf_outa`  in  DATA_W  register file OutA (combinational read).
- `rf_i`  out  DATA_W  register file data input.
- `rf_funsel`  out  3  000 dec, 001 inc, 010 load, 011 clear.
- `rf_regsel`, `rf_scrsel`  out  4 each  active-low enables; bit 3 = R1/S1 … bit 0 = R4/S4.
- `rf_outasel`, `rf_outbsel`  out  3 each  read selects.
- `done`  out  1  one-cycle pulse, command complete.
- `err`  out  1  valid with `done`; command rejected, no write performed.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, SW1, SW2, SW3.
- The accepted command is latched at the accept edge.
- Transitions from IDLE:
  - SWAP goes to SW1.
  - All other opcodes go to EXEC.
- EXEC → IDLE. SW1 → SW2 → SW3 → IDLE.
- Outputs are decoded from the state and the latched command.
- Idle drive (also the reset value):
  - `rf_regsel`=`rf_scrsel`=4'b1111, `rf_funsel`=010, `rf_outasel`=`rf_outbsel`=0, `rf_i`=0.
  - `done`=`err`=0, `busy`=0.
- EXEC, by opcode:
  - LDI: `rf_i`=imm, funsel 010, dst enabled.
  - MOV: `rf_outasel`=src, `rf_i`=`rf_outa`, funsel 010, dst enabled.
  - INC/DEC/CLR: funsel 001/000/011, dst enabled, `rf_i`=0.
  - NOP and illegal (111): no enable asserted.
- SWAP (A=dst, B=src):
  - SW1: outasel=A, `rf_i`=`rf_outa`, load S4 (`rf_scrsel`=1110).
  - SW2: outasel=B, load A.
  - SW3: outasel=7, load B.
- Exactly one enable bit is low in any write cycle. `rf_outbsel` is held at 0.
- Error cases (`err`=1, no enable asserted, single EXEC cycle):
  - Illegal opcode.
  - SWAP with A=7 or B=7.
- SWAP with A=B runs all three cycles; values are unchanged.
- MOV with dst=src is legal.
- `done`/`err` are registered. They assert in the cycle after the final write edge, so register contents are already updated when `done` is seen.

## Timing
- Accept at edge k. Controls are active in cycle k..k+1 and the write happens at edge k+1. `done` is high in cycle k+1..k+2.
- SWAP writes occur at edges k+1, k+2, k+3. `done` follows edge k+3.
- Base build: `cmd_ready` = (state==IDLE). Throughput is one single-cycle command per 2 cycles.
- Asynchronous reset at any point:
  - Outputs return to idle drive immediately.
  - The FSM goes to IDLE and `done` clears.
  - A partially completed SWAP is not rolled back.

## Configuration
- `REGFILE_SEQ_SKID_EN` defined: adds a one-entry command skid buffer.
  - `cmd_ready` = !skid_full, so commands are accepted while busy.
  - At the final-cycle edge of a command, a buffered command moves directly into its first execute state. There is no IDLE bubble, giving back-to-back single-cycle ops at 1 per cycle.
  - If the buffer is empty and the FSM is idle, an incoming command bypasses the buffer.
  - Reset empties the buffer.
- Undefined: no buffer; `cmd_ready` is as in Timing.

## Test plan
- **Reset:** release Reset, idle → `rf_regsel`=`rf_scrsel`=1111, `cmd_ready`=1, `busy`=0. Assert Reset mid-SW2 → same values within the same cycle, and S4 keeps the value written in SW1.
- **LDI:** LDI dst=1 imm=0x1234 → one cycle with `rf_regsel`=1011, funsel 010, `rf_i`=0x1234. `done` follows, `err`=0, R2 reads 0x1234.
- **SWAP:** R1=0x00AA, S1=0x5500; SWAP dst=0 src=4 → scrsel 1110, then regsel 0111, then scrsel 0111 on consecutive cycles. After `done`: R1=0x5500, S1=0x00AA, S4=0x00AA.
- **Errors:** SWAP dst=7 and op=111 → single EXEC cycle with all enables 1111, `done`=`err`=1, and no register changes.
- **Arithmetic:** INC R4 from 0xFFFF → funsel 001, regsel 1110, R4=0x0000. CLR S2 → funsel 011, scrsel 1011.
- **Skid (`REGFILE_SEQ_SKID_EN`):** three LDIs back-to-back with `cmd_valid` held → writes on three consecutive edges and three consecutive `done` pulses. Base build → `cmd_ready` low every other cycle.
